reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined core; successor to the single-write, two-read register file.
- Configurable number of read ports, two write ports with fixed priority, optional write-to-read bypass, hardwired zero register.
- Adds a per-register pending-write scoreboard for hazard detection.
- Adds a sequential clear engine that zeroes the array after reset or on request.

---
 rtl/reg_file_mp.sv | 133 +++++++++++++
 tb/tb_reg_file_mp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file_mp : multi-port register file with pending-write scoreboard and
//               sequential clear engine.                            rev 1.0
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int D_WIDTH       = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_RD        = 2,
  parameter int BYPASS        = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_req,
  output logic                            ready,
  input  logic                            wr0_en,
  input  logic [ADDRESS_WIDTH-1:0]        wr0_addr,
  input  logic [D_WIDTH-1:0]              wr0_data,
  input  logic                            wr1_en,
  input  logic [ADDRESS_WIDTH-1:0]        wr1_addr,
  input  logic [D_WIDTH-1:0]              wr1_data,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*D_WIDTH-1:0]       rd_data,
  output logic [NUM_RD-1:0]               rd_busy,
  input  logic                            busy_set_en,
  input  logic [ADDRESS_WIDTH-1:0]        busy_set_addr
);

  localparam int DEPTH   = 2**ADDRESS_WIDTH;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);
  localparam logic [ADDRESS_WIDTH-1:0] C_LAST = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [D_WIDTH-1:0]       mem_q [DEPTH];
  logic [D_WIDTH-1:0]       mem_d [DEPTH];

  logic w_run;
  logic w_wr_allow;
  logic w_wr0_ok;
  logic w_wr1_ok;
  logic w_set_ok;

  assign w_run      = (state_q == RUN);
  assign ready      = w_run;
  // A clear request in RUN suppresses every update of that cycle.
  assign w_wr_allow = w_run && !clr_req;
  assign w_wr0_ok   = w_wr_allow && wr0_en && !(ZERO_EN && (wr0_addr == '0));
  assign w_wr1_ok   = w_wr_allow && wr1_en && !(ZERO_EN && (wr1_addr == '0));
  assign w_set_ok   = w_wr_allow && busy_set_en && !(ZERO_EN && (busy_set_addr == '0));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    mem_d     = mem_q;
    if (state_q == CLEAR) begin
      mem_d[clr_cnt_q] = '0;
      clr_cnt_d        = clr_cnt_q + ADDRESS_WIDTH'(1);
      if (clr_cnt_q == C_LAST) begin
        state_d = RUN;
      end
    end else if (clr_req) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
      busy_d    = '0;
    end else begin
      // Port 1 is applied last so it wins a same-address collision.
      if (w_wr0_ok) begin
        mem_d[wr0_addr]  = wr0_data;
        busy_d[wr0_addr] = 1'b0;
      end
      if (w_wr1_ok) begin
        mem_d[wr1_addr]  = wr1_data;
        busy_d[wr1_addr] = 1'b0;
      end
      // Set after clear: a new producer issued as the old one retires stays pending.
      if (w_set_ok) begin
        busy_d[busy_set_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Array contents are zeroed by the clear engine, not by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] w_a;
    logic [D_WIDTH-1:0]       w_d;
    logic                     w_b;

    assign w_a = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    always_comb begin
      w_d = '0;
      w_b = 1'b0;
      if (w_run && !(ZERO_EN && (w_a == '0))) begin
        if (BYP_EN && wr1_en && (wr1_addr == w_a)) begin
          w_d = wr1_data;
        end else if (BYP_EN && wr0_en && (wr0_addr == w_a)) begin
          w_d = wr0_data;
        end else begin
          w_d = mem_q[w_a];
          w_b = busy_q[w_a];
        end
      end
    end

    assign rd_data[i*D_WIDTH +: D_WIDTH] = w_d;
    assign rd_busy[i]                    = w_b;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_file_mp : scoreboard bench for reg_file_mp against a reference model.
//                                                                    rev 1.0
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr_req = 1'b0;
  logic             ready;
  logic             wr0_en = 1'b0;
  logic [AW-1:0]    wr0_addr = '0;
  logic [DW-1:0]    wr0_data = '0;
  logic             wr1_en = 1'b0;
  logic [AW-1:0]    wr1_addr = '0;
  logic [DW-1:0]    wr1_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             busy_set_en = 1'b0;
  logic [AW-1:0]    busy_set_addr = '0;

  reg_file_mp #(
    .D_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    busy;
    logic             rdy;
    int               tag;
  } exp_t;

  exp_t q[$];

  // Reference model: register contents, pending flags, cycles left in a clear.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  int            clear_left;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  function automatic void start_clear();
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end
    clear_left = DEPTH;
  endfunction

  function automatic exp_t predict(int tag);
    exp_t e;
    e.data = '0;
    e.busy = '0;
    e.rdy  = (clear_left == 0);
    e.tag  = tag;
    if (e.rdy) begin
      for (int i = 0; i < NR; i++) begin
        int a;
        a = int'(rd_addr[i*AW +: AW]);
        if (a == 0) continue;
        if (wr1_en && int'(wr1_addr) == a)      e.data[i*DW +: DW] = wr1_data;
        else if (wr0_en && int'(wr0_addr) == a) e.data[i*DW +: DW] = wr0_data;
        else begin
          e.data[i*DW +: DW] = m_mem[a];
          e.busy[i]          = m_busy[a];
        end
      end
    end
    return e;
  endfunction

  function automatic void model_edge();
    if (rst) start_clear();
    else if (clear_left > 0) clear_left--;
    else if (clr_req) start_clear();
    else begin
      if (wr0_en && wr0_addr != 0) begin m_mem[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr != 0) begin m_mem[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
      if (busy_set_en && busy_set_addr != 0) m_busy[busy_set_addr] = 1'b1;
    end
  endfunction

  task automatic step(int tag);
    q.push_back(predict(tag));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    clr_req = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; busy_set_en = 1'b0;
  endtask

  task automatic set_rd(int a0, int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic do_reset(int n, int tag);
    rst = 1'b1;
    start_clear();
    repeat (n) step(tag);
    rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  // Stimulus
  initial begin
    start_clear();
    @(posedge clk);
    #1;
    // 1: writes held through reset and clear are ignored
    wr0_en = 1'b1; wr0_addr = AW'(3); wr0_data = 32'hDEAD; set_rd(3, 3);
    do_reset(3, 1);
    repeat (DEPTH) step(1);
    idle();
    step(1);
    // 2: same-address collision, port 1 wins (also via bypass)
    wr0_en = 1'b1; wr0_addr = AW'(5); wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = AW'(5); wr1_data = 32'h22; set_rd(5, 5);
    step(2);
    idle();
    step(2);
    // 3: zero register
    wr1_en = 1'b1; wr1_addr = '0; wr1_data = 32'hFFFF_FFFF;
    busy_set_en = 1'b1; busy_set_addr = '0; set_rd(0, 0);
    step(3);
    idle();
    step(3);
    // 4: scoreboard set / clear / set-wins
    busy_set_en = 1'b1; busy_set_addr = AW'(7); set_rd(7, 6);
    step(4);
    idle();
    step(4);
    wr0_en = 1'b1; wr0_addr = AW'(7); wr0_data = 32'h5;
    step(4);
    idle();
    step(4);
    busy_set_en = 1'b1; busy_set_addr = AW'(7);
    wr0_en = 1'b1; wr0_addr = AW'(7); wr0_data = 32'h6;
    step(4);
    idle();
    step(4);
    // 5: clear request wipes data and busy bits
    wr0_en = 1'b1; wr0_addr = AW'(1); wr0_data = 32'hA1;
    wr1_en = 1'b1; wr1_addr = AW'(2); wr1_data = 32'hA2;
    busy_set_en = 1'b1; busy_set_addr = AW'(2);
    step(5);
    wr0_addr = AW'(3); wr0_data = 32'hA3;
    wr1_addr = AW'(4); wr1_data = 32'hA4; busy_set_addr = AW'(3);
    step(5);
    idle();
    set_rd(1, 2);
    step(5);
    clr_req = 1'b1;
    step(5);
    idle();
    repeat (DEPTH) step(5);
    step(5);
    set_rd(3, 4);
    step(5);
    // 6: reset ten cycles into a clear restarts it
    clr_req = 1'b1;
    step(6);
    idle();
    repeat (10) step(6);
    do_reset(2, 6);
    repeat (DEPTH + 2) step(6);
    // 7: randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      wr0_en        = ($urandom_range(0, 1) == 1);
      wr0_addr      = rand_addr();
      wr0_data      = $urandom;
      wr1_en        = ($urandom_range(0, 2) == 0);
      wr1_addr      = rand_addr();
      wr1_data      = $urandom;
      busy_set_en   = ($urandom_range(0, 2) == 0);
      busy_set_addr = rand_addr();
      clr_req       = ($urandom_range(0, 149) == 0);
      rd_addr       = {rand_addr(), rand_addr()};
      if ($urandom_range(0, 799) == 0) do_reset(int'($urandom_range(1, 3)), 7);
      else step(7);
    end
    idle();
    step(8);
    done = 1'b1;
  end

  // Monitor: one expected response per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ready !== e.rdy) begin
          errors++;
          $display("FAIL ready tag=%0d t=%0t actual=%b required=%b", e.tag, $time, ready, e.rdy);
        end
        checks++;
        if (rd_data !== e.data) begin
          errors++;
          $display("FAIL rd_data tag=%0d t=%0t addr=%h actual=%h required=%h",
                   e.tag, $time, rd_addr, rd_data, e.data);
        end
        checks++;
        if (rd_busy !== e.busy) begin
          errors++;
          $display("FAIL rd_busy tag=%0d t=%0t addr=%h actual=%b required=%b",
                   e.tag, $time, rd_addr, rd_busy, e.busy);
        end
      end else if (done) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
